// File: rtl/mem_seq_ctrl.sv
// Sequences single-word, byte-lane and pointer-indirect memory accesses behind a valid/ready request port.
// Define MEM_SEQ_TIMEOUT_EN to abort MEM1/MEM2 waits after TIMEOUT_CYC cycles without mem_resp.
module mem_seq_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_op,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [$clog2(DATA_W/8)-1:0]   req_lane,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [DATA_W/8-1:0]           mem_byte_enable,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_resp
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  localparam logic [2:0] OP_READ       = 3'd0;
  localparam logic [2:0] OP_WRITE      = 3'd1;
  localparam logic [2:0] OP_READ_BYTE  = 3'd2;
  localparam logic [2:0] OP_WRITE_BYTE = 3'd3;
  localparam logic [2:0] OP_READ_IND   = 3'd4;
  localparam logic [2:0] OP_WRITE_IND  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_MEM1, S_PTR, S_MEM2, S_RESP} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LANE_W-1:0]   lane_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                is_ind;
  logic                first_is_read;
  logic                first_is_write;
  logic [7:0]          lane_byte;
  logic [DATA_W-1:0]   load_data;

  assign is_ind         = (op_q == OP_READ_IND) || (op_q == OP_WRITE_IND);
  assign first_is_read  = (op_q == OP_READ) || (op_q == OP_READ_BYTE) || is_ind;
  assign first_is_write = (op_q == OP_WRITE) || (op_q == OP_WRITE_BYTE);
  assign lane_byte      = mem_rdata[{lane_q, 3'b000} +: 8];
  assign load_data      = (op_q == OP_READ_BYTE) ? {{(DATA_W-8){1'b0}}, lane_byte} : mem_rdata;

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_SEQ_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
`ifdef MEM_SEQ_TIMEOUT_EN
      // Cleared everywhere except while waiting, so every MEM state entry starts from zero.
      wait_cnt <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            lane_q  <= req_lane;
            rdata_q <= '0;
            if (req_op <= OP_WRITE_IND) begin
              err_q <= 1'b0;
              state <= S_MEM1;
            end else begin
              err_q <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_MEM1, S_MEM2: begin
          if (mem_resp) begin
            if (state == S_MEM1 && is_ind) begin
              ptr_q <= mem_rdata[ADDR_W-1:0];
              state <= S_PTR;
            end else begin
              rdata_q <= (state == S_MEM1) ? load_data : mem_rdata;
              state   <= S_RESP;
            end
          end
`ifdef MEM_SEQ_TIMEOUT_EN
          else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_PTR: begin
          addr_q <= ptr_q;
          state  <= S_MEM2;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_err     = (state == S_RESP) && err_q;
  assign rsp_rdata   = rdata_q;
  assign mem_address = addr_q;
  assign mem_read    = ((state == S_MEM1) && first_is_read) ||
                       ((state == S_MEM2) && (op_q == OP_READ_IND));
  assign mem_write   = ((state == S_MEM1) && first_is_write) ||
                       ((state == S_MEM2) && (op_q == OP_WRITE_IND));
  assign mem_wdata   = (op_q == OP_WRITE_BYTE) ? {NB{wdata_q[7:0]}} : wdata_q;
  assign mem_byte_enable = ((state == S_MEM1) && (op_q == OP_WRITE_BYTE)) ?
                           ({{(NB-1){1'b0}}, 1'b1} << lane_q) : {NB{1'b1}};

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: a word-addressed memory responder with scripted wait states,
// checked against a reference memory updated from the access rules of each opcode.
module tb_mem_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_lane;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] dut_mem [logic [15:0]];
  int          wait_q [$];
  logic [15:0] log_addr [$];
  logic        log_wr [$];
  logic [15:0] log_wdata [$];
  logic [1:0]  log_be [$];
  logic        busy;
  int          wl;

  mem_seq_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_lane(req_lane),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] dut_rd(input logic [15:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_val(a);
  endfunction

  // Memory responder: one access per strobe episode, wait count taken from wait_q.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = 16'h0;
    busy      = 1'b0;
    wl        = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy     = 1'b0;
        mem_resp = 1'b0;
      end else if (mem_resp) begin
        mem_resp  = 1'b0;
        busy      = 1'b0;
        mem_rdata = 16'($urandom);
      end else if (mem_read || mem_write) begin
        if (!busy) begin
          busy = 1'b1;
          wl   = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          log_addr.push_back(mem_address);
          log_wr.push_back(mem_write);
          log_wdata.push_back(mem_wdata);
          log_be.push_back(mem_byte_enable);
        end
        if (wl == 0) begin
          if (mem_write) begin
            logic [15:0] cur;
            cur = dut_rd(mem_address);
            if (mem_byte_enable[0]) cur[7:0]  = mem_wdata[7:0];
            if (mem_byte_enable[1]) cur[15:8] = mem_wdata[15:8];
            dut_mem[mem_address] = cur;
            mem_rdata = 16'($urandom);
          end else begin
            mem_rdata = dut_rd(mem_address);
          end
          mem_resp = 1'b1;
        end else begin
          wl = wl - 1;
        end
      end
    end
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    ref_mem[a] = v;
    dut_mem[a] = v;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic lane, input int w0, input int w1);
    logic [15:0] e_addr [2];
    logic        e_wr [2];
    logic [15:0] e_wd [2];
    logic [1:0]  e_be [2];
    int          n_acc;
    logic [15:0] e_rdata;
    logic [15:0] old;
    logic [15:0] ptr;
    logic        e_err;
    logic        chk_data;
    int          e_lat;
    int          lat;
    bit          got;
    n_acc = 0; e_err = 1'b0; e_rdata = 16'h0; chk_data = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_addr[i] = '0; e_wr[i] = 1'b0; e_wd[i] = '0; e_be[i] = 2'b11;
    end
    case (op)
      3'd0: begin
        e_addr[0] = addr; n_acc = 1; e_rdata = ref_rd(addr); chk_data = 1'b1;
      end
      3'd1: begin
        e_addr[0] = addr; e_wr[0] = 1'b1; e_wd[0] = wdata; n_acc = 1;
        ref_mem[addr] = wdata;
      end
      3'd2: begin
        e_addr[0] = addr; n_acc = 1; old = ref_rd(addr); chk_data = 1'b1;
        e_rdata = lane ? {8'h00, old[15:8]} : {8'h00, old[7:0]};
      end
      3'd3: begin
        e_addr[0] = addr; e_wr[0] = 1'b1; e_wd[0] = {wdata[7:0], wdata[7:0]};
        e_be[0] = lane ? 2'b10 : 2'b01; n_acc = 1;
        old = ref_rd(addr);
        ref_mem[addr] = lane ? {wdata[7:0], old[7:0]} : {old[15:8], wdata[7:0]};
      end
      3'd4: begin
        ptr = ref_rd(addr);
        e_addr[0] = addr; e_addr[1] = ptr; n_acc = 2;
        e_rdata = ref_rd(ptr); chk_data = 1'b1;
      end
      3'd5: begin
        ptr = ref_rd(addr);
        e_addr[0] = addr; e_addr[1] = ptr; e_wr[1] = 1'b1; e_wd[1] = wdata; n_acc = 2;
        ref_mem[ptr] = wdata;
      end
      default: begin
        e_err = 1'b1; chk_data = 1'b1;
      end
    endcase
    e_lat = (op > 3'd5) ? 1 : (op >= 3'd4) ? (4 + w0 + w1) : (2 + w0);

    wait_q.delete(); log_addr.delete(); log_wr.delete(); log_wdata.delete(); log_be.delete();
    wait_q.push_back(w0);
    if (op >= 3'd4) wait_q.push_back(w1);

    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_req op=%0d: got %b expected 1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_lane = lane;
    @(posedge clk);
    #1;
    // Keep junk requests on the port while busy; they must not be captured.
    req_op = 3'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom); req_lane = 1'($urandom);
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = i;
      end
    end
    req_valid = 1'b0;

    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL rsp_timeout op=%0d: no rsp_valid within 60 cycles", op);
    end else begin
      n_checks++;
      if (lat != e_lat) begin
        n_fail++; $display("FAIL latency op=%0d: got %0d expected %0d", op, lat, e_lat);
      end
      n_checks++;
      if (rsp_err !== e_err) begin
        n_fail++; $display("FAIL rsp_err op=%0d: got %b expected %b", op, rsp_err, e_err);
      end
      if (chk_data) begin
        n_checks++;
        if (rsp_rdata !== e_rdata) begin
          n_fail++; $display("FAIL rsp_rdata op=%0d: got %h expected %h", op, rsp_rdata, e_rdata);
        end
      end
      n_checks++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_in_resp op=%0d: got %b expected 0", op, req_ready);
      end
    end

    n_checks++;
    if (log_addr.size() != n_acc) begin
      n_fail++; $display("FAIL access_count op=%0d: got %0d expected %0d", op, log_addr.size(), n_acc);
    end
    for (int i = 0; i < n_acc && i < log_addr.size(); i++) begin
      n_checks++;
      if (log_addr[i] !== e_addr[i] || log_wr[i] !== e_wr[i] || log_be[i] !== e_be[i] ||
          (e_wr[i] && log_wdata[i] !== e_wd[i])) begin
        n_fail++;
        $display("FAIL access%0d op=%0d: got addr=%h wr=%b be=%b wd=%h expected addr=%h wr=%b be=%b wd=%h",
                 i, op, log_addr[i], log_wr[i], log_be[i], log_wdata[i], e_addr[i], e_wr[i], e_be[i], e_wd[i]);
      end
    end

    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_resp op=%0d: got valid=%b ready=%b expected valid=0 ready=1", op, rsp_valid, req_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || mem_byte_enable !== 2'b11 || rsp_rdata !== 16'h0 ||
        mem_address !== 16'h0 || mem_wdata !== 16'h0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b vld=%b err=%b rd=%b wr=%b be=%b rdata=%h addr=%h wdata=%h expected 1 0 0 0 0 11 0 0 0",
               tag, req_ready, rsp_valid, rsp_err, mem_read, mem_write, mem_byte_enable,
               rsp_rdata, mem_address, mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0; req_wdata = 16'h0; req_lane = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_directed();
    preload(16'h0040, 16'hBEEF);
    do_op(3'd0, 16'h0040, 16'h0000, 1'b0, 0, 0);
    do_op(3'd3, 16'h0050, 16'h00A5, 1'b1, 3, 0);
    do_op(3'd0, 16'h0050, 16'h0000, 1'b0, 1, 0);
    preload(16'h0010, 16'h0200);
    preload(16'h0200, 16'h1234);
    do_op(3'd4, 16'h0010, 16'h0000, 1'b0, 0, 0);
    do_op(3'd4, 16'h0010, 16'h0000, 1'b0, 2, 3);
    do_op(3'd7, 16'h0033, 16'hFFFF, 1'b1, 0, 0);
    do_op(3'd6, 16'h0034, 16'h1111, 1'b0, 0, 0);
    do_op(3'd2, 16'h0040, 16'h0000, 1'b1, 2, 0);
    do_op(3'd2, 16'h0040, 16'h0000, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom_range(0, 31)), 16'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      do_op(3'(k % 6), 16'(k + 8), 16'($urandom), 1'(k), 0, 0);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [15:0] ptr;
    bit          got;
    ptr = ref_rd(16'h0020);
    wait_q.delete(); log_addr.delete(); log_wr.delete(); log_wdata.delete(); log_be.delete();
    wait_q.push_back(0);
    wait_q.push_back(30);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 16'h0020; req_wdata = 16'h7777; req_lane = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_write) got = 1'b1;
    end
    n_checks++;
    if (!got || mem_address !== ptr) begin
      n_fail++; $display("FAIL mem2_write_reached: got seen=%b addr=%h expected seen=1 addr=%h", got, mem_address, ptr);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_mem2");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_mid_reset");
    do_op(3'd0, ptr, 16'h0000, 1'b0, 0, 0);
    do_op(3'd5, 16'h0020, 16'h7777, 1'b0, 1, 1);
    do_op(3'd0, ptr, 16'h0000, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: memory word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter ADDR_W, default 16: address width in bits; SHALL be no greater than DATA_W.
REQ-003 Parameter TIMEOUT_CYC, default 255: number of wait cycles without mem_resp before an access is aborted.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_op  in  3  0 READ, 1 WRITE, 2 READ_BYTE, 3 WRITE_BYTE, 4 READ_IND, 5 WRITE_IND; 6 and 7 are illegal.
REQ-009 req_addr  in  ADDR_W  access address (pointer address for IND ops).
REQ-010 req_wdata  in  DATA_W  store data; byte ops use bits [7:0].
REQ-011 req_lane  in  clog2(DATA_W/8)  byte lane for byte ops.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  load result, valid while rsp_valid=1.
REQ-014 rsp_err  out  1  error flag, valid while rsp_valid=1.
REQ-015 mem_address  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_read  out  1  memory read strobe.
REQ-018 mem_write  out  1  memory write strobe.
REQ-019 mem_byte_enable  out  DATA_W/8  memory write lane mask.
REQ-020 mem_rdata  in  DATA_W  memory read data.
REQ-021 mem_resp  in  1  memory completion, single cycle.

Function
REQ-022 States SHALL be IDLE, MEM1, PTR, MEM2, RESP; all outputs SHALL be decoded from state and capture registers only (Moore).
REQ-023 In IDLE, req_ready=1 and all other strobes=0; req_ready=0 in all other states, and req_valid SHALL be ignored outside IDLE.
REQ-024 On IDLE with req_valid=1, op, addr, wdata and lane SHALL be captured; a legal op SHALL go to MEM1, an illegal op to RESP with the error flag set.
REQ-025 In MEM1, mem_address=captured addr; mem_read=1 for READ, READ_BYTE and both IND ops; mem_write=1 for WRITE and WRITE_BYTE; the strobe SHALL be held until mem_resp.
REQ-026 MEM1 with mem_resp=1: IND ops SHALL latch mem_rdata[ADDR_W-1:0] as the pointer and go to PTR; other ops SHALL latch read data and go to RESP.
REQ-027 PTR SHALL last one cycle with no strobes, load the address register from the pointer, and go to MEM2.
REQ-028 In MEM2, READ_IND SHALL assert mem_read and WRITE_IND SHALL assert mem_write at the pointer, held until mem_resp; then latch data and go to RESP.
REQ-029 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE.
REQ-030 mem_byte_enable SHALL be all-ones except during WRITE_BYTE, where it SHALL be one-hot at req_lane.
REQ-031 WRITE_BYTE mem_wdata SHALL be wdata[7:0] replicated into every lane; other writes SHALL drive full wdata.
REQ-032 READ_BYTE rsp_rdata SHALL be the selected lane byte, zero-extended; full reads SHALL return mem_rdata unchanged.
REQ-033 Latency from request accept to rsp_valid SHALL be 2 cycles plus memory wait cycles (single access), or 4 cycles plus both waits (IND ops).
REQ-034 mem_resp SHALL be ignored in IDLE, PTR and RESP.
REQ-035 On an error response, rsp_rdata SHALL be 0.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE and clear req_ready to 1, rsp_valid, rsp_err, mem_read and mem_write to 0, mem_byte_enable to all-ones, and rsp_rdata, mem_address and mem_wdata to 0, including mid-access.

Configuration
REQ-037 When MEM_SEQ_TIMEOUT_EN is defined, a counter SHALL count MEM1/MEM2 cycles without mem_resp and clear on state entry; on reaching TIMEOUT_CYC the access SHALL abort to RESP with rsp_err=1.
REQ-038 If mem_resp arrives in the timeout cycle, mem_resp SHALL take priority and no error SHALL be raised.
REQ-039 Without MEM_SEQ_TIMEOUT_EN, no counter SHALL exist, MEM states SHALL wait indefinitely, and rsp_err SHALL flag illegal ops only.

Verification
REQ-040 READ addr 0x0040, mem_resp on first MEM1 cycle, mem_rdata 0xBEEF -> rsp_valid 2 cycles after accept, rsp_rdata 0xBEEF, rsp_err 0.
REQ-041 WRITE_BYTE lane 1, wdata 0x00A5, DATA_W 16 -> mem_byte_enable 2'b10, mem_wdata 0xA5A5, mem_write held through 3 wait cycles.
REQ-042 READ_IND addr 0x0010, memory returns 0x0200 then 0x1234 -> second mem_address 0x0200, rsp_rdata 0x1234, one idle PTR cycle between reads.
REQ-043 req_op 7 -> no memory strobe; rsp_valid with rsp_err=1 one cycle after accept.
REQ-044 With MEM_SEQ_TIMEOUT_EN and TIMEOUT_CYC 4, no mem_resp -> strobe drops, rsp_err=1, rsp_rdata 0; same case with mem_resp in the 4th cycle -> no error.
REQ-045 rst_n low during MEM2 of WRITE_IND -> mem_write drops without waiting for a clock edge; block in IDLE with req_ready=1 after release.
